// File: rtl/mspu_pkg.sv
// mspu_pkg
//   Shared definitions for the stream-core allocator and its helpers.
//   CORE_ID_W(cores) : width of a core index for a given core count.
//   GRANT_COUNT_W    : width of the running grant counter.
package mspu_pkg;

  localparam int GRANT_COUNT_W = 32;

  // Core counts are at least 2, so this is always at least 1 bit wide.
  function automatic int CORE_ID_W(input int cores);
    return (cores <= 2) ? 1 : $clog2(cores);
  endfunction

endpackage

// File: rtl/stream_core_allocator_rr_idle_picker.sv
// rr_idle_picker
//   Purely combinational rotating first-set search. It returns the first
//   set bit of cand, searching upward from rr_ptr and wrapping CORES-1 -> 0.
//   Ports:
//     cand   in  CORES      candidate vector
//     rr_ptr in  CORE_ID_W  search start position (always < CORES)
//     found  out 1          cand has at least one set bit
//     index  out CORE_ID_W  first set position at or after rr_ptr; 0 if none
module rr_idle_picker
  import mspu_pkg::*;
#(
  parameter int CORES = 4
) (
  input  logic [CORES-1:0]            cand,
  input  logic [CORE_ID_W(CORES)-1:0] rr_ptr,
  output logic                        found,
  output logic [CORE_ID_W(CORES)-1:0] index
);

  localparam int IW = CORE_ID_W(CORES);
  localparam logic [IW:0] CORES_N = (IW+1)'(CORES);

  logic [IW:0] pos;

  // Walk offsets from the farthest to the nearest so the nearest hit is
  // the last one written and therefore wins.
  always_comb begin
    found = |cand;
    index = '0;
    pos   = '0;
    for (int k = CORES - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= CORES_N) pos = pos - CORES_N;
      if (cand[pos[IW-1:0]]) index = pos[IW-1:0];
    end
  end

endmodule

// File: rtl/stream_core_allocator.sv
// stream_core_allocator
//   Tracks which processing cores are busy with a stream job and offers one
//   idle, enabled core at a time to the stream parser, round-robin.
//
//   Handshake: core_valid/core_id is a combinational offer derived only from
//   registered state and core_enable. The parser commits by pulsing
//   grant_valid with grant_id for one cycle; an accepted commit takes effect
//   on the next rising edge (core marked busy, offer moves on). grant_valid
//   does not wait on core_valid: a commit to a busy, disabled or
//   out-of-range core is refused and raises err_grant_busy.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     core_enable       per-core enable; disabled cores are never offered
//     core_done         per-core one-cycle pulse: job finished, release core
//     core_valid        an idle enabled core is offered
//     core_id           offered core index (0 when nothing offered)
//     grant_valid       parser committed a packet to grant_id
//     grant_id          committed core index
//     busy_mask         registered occupancy vector
//     idle_count        number of enabled, non-busy cores
//     grant_count       accepted grants, wraps modulo 2^32
//     err_grant_busy    sticky: refused grant
//     err_done_idle     sticky: core_done on a core that was not busy
module stream_core_allocator
  import mspu_pkg::*;
#(
  parameter int CORES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CORES-1:0]            core_enable,
  input  logic [CORES-1:0]            core_done,
  output logic                        core_valid,
  output logic [CORE_ID_W(CORES)-1:0] core_id,
  input  logic                        grant_valid,
  input  logic [CORE_ID_W(CORES)-1:0] grant_id,
  output logic [CORES-1:0]            busy_mask,
  output logic [CORE_ID_W(CORES):0]   idle_count,
  output logic [GRANT_COUNT_W-1:0]    grant_count,
  output logic                        err_grant_busy,
  output logic                        err_done_idle
);

  localparam int IW = CORE_ID_W(CORES);
  localparam logic [IW:0]   CORES_N = (IW+1)'(CORES);
  localparam logic [IW-1:0] LAST_ID = IW'(CORES - 1);

  logic [CORES-1:0]         busy_mask_q;
  logic [IW-1:0]            rr_ptr_q;
  logic [GRANT_COUNT_W-1:0] grant_count_q;
  logic                     err_grant_busy_q;
  logic                     err_done_idle_q;

  logic [CORES-1:0] cand;
  logic [CORES-1:0] grant_onehot;
  logic [CORES-1:0] busy_released;
  logic             grant_in_range;
  logic             grant_ok;
  logic             grant_bad;
  logic             done_bad;
  logic [IW-1:0]    rr_next;

  // Offer side: registers and core_enable only.
  assign cand = core_enable & ~busy_mask_q;

  rr_idle_picker #(
    .CORES (CORES)
  ) u_picker (
    .cand   (cand),
    .rr_ptr (rr_ptr_q),
    .found  (core_valid),
    .index  (core_id)
  );

  always_comb begin
    idle_count = '0;
    for (int i = 0; i < CORES; i++) idle_count = idle_count + (IW+1)'(cand[i]);
  end

  // Update side. Releases are applied before the grant is judged, so a core
  // finishing this very cycle can be re-granted without an error.
  assign grant_in_range = ({1'b0, grant_id} < CORES_N);
  assign grant_onehot   = grant_in_range ? ({{(CORES-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign busy_released  = busy_mask_q & ~core_done;
  assign grant_ok       = grant_valid & (|(grant_onehot & core_enable & ~busy_released));
  assign grant_bad      = grant_valid & ~grant_ok;
  assign done_bad       = |(core_done & ~busy_mask_q);
  assign rr_next        = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask_q      <= '0;
      rr_ptr_q         <= '0;
      grant_count_q    <= '0;
      err_grant_busy_q <= 1'b0;
      err_done_idle_q  <= 1'b0;
    end else begin
      busy_mask_q <= busy_released | (grant_ok ? grant_onehot : '0);
      if (grant_ok) begin
        rr_ptr_q      <= rr_next;
        grant_count_q <= grant_count_q + 32'd1;
      end
      if (grant_bad) err_grant_busy_q <= 1'b1;
      if (done_bad)  err_done_idle_q  <= 1'b1;
    end
  end

  assign busy_mask      = busy_mask_q;
  assign grant_count    = grant_count_q;
  assign err_grant_busy = err_grant_busy_q;
  assign err_done_idle  = err_done_idle_q;

endmodule

// File: tb/tb_stream_core_allocator.sv
module tb_stream_core_allocator;

  localparam int CORES = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_enable;
  logic [3:0]  core_done;
  logic        core_valid;
  logic [1:0]  core_id;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [3:0]  busy_mask;
  logic [2:0]  idle_count;
  logic [31:0] grant_count;
  logic        err_grant_busy;
  logic        err_done_idle;

  always #5 clk = ~clk;

  stream_core_allocator #(.CORES(CORES)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_enable    (core_enable),
    .core_done      (core_done),
    .core_valid     (core_valid),
    .core_id        (core_id),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .busy_mask      (busy_mask),
    .idle_count     (idle_count),
    .grant_count    (grant_count),
    .err_grant_busy (err_grant_busy),
    .err_done_idle  (err_done_idle)
  );

  // ---------------- reference model ----------------
  bit          m_busy[CORES];
  int          m_rr;
  bit [31:0]   m_gcount;
  bit          m_err_grant;
  bit          m_err_done;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic int m_idle(input logic [3:0] en);
    int n = 0;
    for (int i = 0; i < CORES; i++) if (en[i] && !m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_offer(input logic [3:0] en);
    for (int k = 0; k < CORES; k++) begin
      int c = (m_rr + k) % CORES;
      if (en[c] && !m_busy[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [3:0] m_busy_vec();
    logic [3:0] v = '0;
    for (int i = 0; i < CORES; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_update(input logic [3:0] en, input logic [3:0] done,
                          input logic gv, input int gid, input logic rst);
    if (rst) begin
      for (int i = 0; i < CORES; i++) m_busy[i] = 0;
      m_rr = 0; m_gcount = 0; m_err_grant = 0; m_err_done = 0;
      return;
    end
    for (int i = 0; i < CORES; i++)
      if (done[i]) begin
        if (m_busy[i]) m_busy[i] = 0;
        else m_err_done = 1;
      end
    if (gv) begin
      if (gid < CORES && en[gid] && !m_busy[gid]) begin
        m_busy[gid] = 1;
        m_rr = (gid + 1) % CORES;
        m_gcount = m_gcount + 1;
      end else begin
        m_err_grant = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_offer(input string tag);
    check({tag, ".core_valid"}, 32'(core_valid), 32'(m_idle(core_enable) > 0));
    check({tag, ".core_id"},    32'(core_id),    32'(m_offer(core_enable)));
    check({tag, ".idle_count"}, 32'(idle_count), 32'(m_idle(core_enable)));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".busy_mask"},   32'(busy_mask),      32'(m_busy_vec()));
    check({tag, ".grant_count"}, grant_count,         m_gcount);
    check({tag, ".err_grant"},   32'(err_grant_busy), 32'(m_err_grant));
    check({tag, ".err_done"},    32'(err_done_idle),  32'(m_err_done));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, check the offer before the edge, clock,
  // update the model, check everything after the edge.
  task automatic step(input string tag, input logic [3:0] en, input logic [3:0] done,
                      input logic gv, input logic [1:0] gid, input logic rst);
    core_enable = en; core_done = done; grant_valid = gv; grant_id = gid; reset = rst;
    #1;
    if (!rst) check_offer({tag, ".pre"});
    @(posedge clk);
    m_update(en, done, gv, int'(gid), rst);
    @(negedge clk);
    core_done = '0; grant_valid = 1'b0; reset = 1'b0;
    #1;
    check_regs(tag);
    check_offer({tag, ".post"});
  endtask

  task automatic do_reset(input logic [3:0] en);
    step("reset", en, 4'b0000, 1'b0, 2'd0, 1'b1);
  endtask

  initial begin
    logic [3:0] en, done;
    logic       gv;
    logic [1:0] gid;

    reset = 1'b1; core_enable = 4'b1111; core_done = '0;
    grant_valid = 1'b0; grant_id = '0;
    @(negedge clk);

    // Reset state with all cores enabled.
    do_reset(4'b1111);
    check("rst.core_valid", 32'(core_valid), 32'd1);
    check("rst.core_id",    32'(core_id),    32'd0);
    check("rst.idle",       32'(idle_count), 32'd4);
    check("rst.busy",       32'(busy_mask),  32'd0);

    // Grant every core in offer order, then release core 2.
    for (int i = 0; i < CORES; i++)
      step("fill", 4'b1111, 4'b0000, 1'b1, 2'(m_offer(4'b1111)), 1'b0);
    check("fill.busy",  32'(busy_mask),   32'hF);
    check("fill.valid", 32'(core_valid),  32'd0);
    check("fill.count", grant_count,      32'd4);
    step("rel2", 4'b1111, 4'b0100, 1'b0, 2'd0, 1'b0);
    check("rel2.core_id", 32'(core_id),    32'd2);
    check("rel2.valid",   32'(core_valid), 32'd1);

    // Bad grant to a busy core, then done on an idle core.
    step("bad_grant", 4'b1111, 4'b0000, 1'b1, 2'd3, 1'b0);
    check("bad_grant.err",   32'(err_grant_busy), 32'd1);
    check("bad_grant.count", grant_count,         32'd4);
    do_reset(4'b1111);
    step("bad_done", 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b0);
    check("bad_done.err", 32'(err_done_idle), 32'd1);

    // Same-cycle release and re-grant of the same core.
    do_reset(4'b1111);
    step("g1", 4'b1111, 4'b0000, 1'b1, 2'd1, 1'b0);
    step("rel_regrant", 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0);
    check("rel_regrant.busy", 32'(busy_mask),      32'h2);
    check("rel_regrant.eg",   32'(err_grant_busy), 32'd0);
    check("rel_regrant.ed",   32'(err_done_idle),  32'd0);
    check("rel_regrant.id",   32'(core_id),        32'd2);

    // Done and grant on different cores in one cycle.
    step("mix", 4'b1111, 4'b0010, 1'b1, 2'd2, 1'b0);

    // Partial enable with rr_ptr at 2.
    do_reset(4'b1111);
    step("g1b", 4'b1111, 4'b0000, 1'b1, 2'd1, 1'b0);
    step("r1b", 4'b1010, 4'b0010, 1'b0, 2'd0, 1'b0);
    check("en1010.id", 32'(core_id), 32'd3);
    step("g3", 4'b1010, 4'b0000, 1'b1, 2'd3, 1'b0);
    check("en1010.id2", 32'(core_id), 32'd1);
    step("g1c", 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b0);
    check("en1010.valid", 32'(core_valid), 32'd0);
    // Disabling a busy core keeps it busy; done still releases it.
    step("dis", 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
    step("dis_rel", 4'b0010, 4'b1000, 1'b0, 2'd0, 1'b0);
    // Grant to a disabled core is refused.
    step("dis_grant", 4'b0010, 4'b0000, 1'b1, 2'd0, 1'b0);

    // Counter wrap from a preloaded value.
    do_reset(4'b1111);
    dut.grant_count_q <= 32'hFFFF_FFFF;
    m_gcount = 32'hFFFF_FFFF;
    #1;
    step("wrap", 4'b1111, 4'b0000, 1'b1, 2'd0, 1'b0);
    check("wrap.count", grant_count, 32'd0);

    // Reset mid-job with done pulses in the reset cycle.
    step("job", 4'b1111, 4'b0000, 1'b1, 2'd1, 1'b0);
    step("mid_reset", 4'b1111, 4'b0011, 1'b0, 2'd0, 1'b1);
    check("mid_reset.busy", 32'(busy_mask),     32'd0);
    check("mid_reset.ed",   32'(err_done_idle), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      if ($urandom_range(0, 9) == 0) done = 4'($urandom_range(0, 15));
      else done = m_busy_vec() & 4'($urandom_range(0, 15));
      gv  = ($urandom_range(0, 1) == 1);
      gid = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_offer(en));
      step("rand", en, done, gv, gid, ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
